riscv_trace_buffer: RTL and testbench

//  Captures the core's architectural side-effects: register writes and data-memory reads/writes.

---
 rtl/riscv_trace_buffer.sv | 137 +++++++++++++
 tb/tb_riscv_trace_buffer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trace_buffer.sv
// Trace buffer for core side-effects: register writes and data-memory accesses.
// Events are stamped, queued in a FIFO and drained over a valid/ready port.
module riscv_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int DEPTH     = 16,
  parameter int STAMP_W   = 16,
  parameter int TRIG_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  input  logic                       trig_en,
  input  logic [ADDR_W-1:0]          trig_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_kind,
  output logic [ADDR_W-1:0]          out_tag,
  output logic [DATA_W-1:0]          out_data,
  output logic [STAMP_W-1:0]         out_stamp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                overflow_cnt,
  output logic                       frozen
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]         kind_q  [DEPTH];
  logic [ADDR_W-1:0]  tag_q   [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [STAMP_W-1:0] stamp_q [DEPTH];

  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW-1:0]      reg_ptr;
  logic [STAMP_W-1:0] stamp;
  logic               cap;
  logic               mem_ev;
  logic               reg_ev;
  logic               push_mem;
  logic               push_reg;
  logic               pop;
  logic               hit;
  logic [CW-1:0]      free;
  logic [1:0]         n_drop;
  logic [16:0]        ovf_sum;
  logic [1:0]         mem_kind;
  logic [DATA_W-1:0]  mem_data;

  // Event qualification, space check (pre-pop) and drop accounting
  always_comb begin
    cap      = enable & ~frozen & ~clear;
    mem_ev   = cap & (wr | rd);
    reg_ev   = cap & reg_write_sig;
    free     = FULL - count;
    push_mem = mem_ev & (free != '0);
    push_reg = reg_ev & (free > CW'(mem_ev));
    n_drop   = 2'(mem_ev & ~push_mem) + 2'(reg_ev & ~push_reg);
    ovf_sum  = {1'b0, overflow_cnt} + 17'(n_drop);
    hit      = (TRIG_MODE != 0) & mem_ev & trig_en & (addr == trig_addr);
    pop      = out_valid & out_ready & ~clear;
    reg_ptr  = wptr + PW'(push_mem);
    mem_kind = wr ? 2'b11 : 2'b10;
    mem_data = wr ? wr_data : rd_data;
  end

  // Control state: stamp, pointers, occupancy, overflow, freeze
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stamp        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overflow_cnt <= '0;
      frozen       <= 1'b0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
      if (clear) begin
        wptr         <= '0;
        rptr         <= '0;
        count        <= '0;
        overflow_cnt <= '0;
        frozen       <= 1'b0;
      end else begin
        wptr  <= wptr + PW'(push_mem) + PW'(push_reg);
        rptr  <= rptr + PW'(pop);
        count <= count + CW'(push_mem) + CW'(push_reg) - CW'(pop);
        overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
        if (hit) frozen <= 1'b1;
      end
    end
  end

  // Entry storage: mem entry first, reg entry in the following slot
  always_ff @(posedge clk) begin
    if (push_mem) begin
      kind_q[wptr]  <= mem_kind;
      tag_q[wptr]   <= addr;
      data_q[wptr]  <= mem_data;
      stamp_q[wptr] <= stamp;
    end
    if (push_reg) begin
      kind_q[reg_ptr]  <= 2'b01;
      tag_q[reg_ptr]   <= ADDR_W'(reg_num);
      data_q[reg_ptr]  <= reg_data;
      stamp_q[reg_ptr] <= stamp;
    end
  end

  assign out_valid = (count != '0);

  // Fall-through head view, zeroed when empty
  always_comb begin
    out_kind  = '0;
    out_tag   = '0;
    out_data  = '0;
    out_stamp = '0;
    if (out_valid) begin
      out_kind  = kind_q[rptr];
      out_tag   = tag_q[rptr];
      out_data  = data_q[rptr];
      out_stamp = stamp_q[rptr];
    end
  end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: directed scenarios plus random traffic
// checked against a queue-based model of the trace FIFO.
module tb_riscv_trace_buffer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 16;
  localparam int CW      = $clog2(DEPTH+1);
  localparam int BW      = 1+2+ADDR_W+DATA_W+STAMP_W+CW+16+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               enable;
  logic               clear;
  logic               reg_write_sig;
  logic [4:0]         reg_num;
  logic [DATA_W-1:0]  reg_data;
  logic               wr;
  logic               rd;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  rd_data;
  logic               trig_en;
  logic [ADDR_W-1:0]  trig_addr;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_kind;
  logic [ADDR_W-1:0]  out_tag;
  logic [DATA_W-1:0]  out_data;
  logic [STAMP_W-1:0] out_stamp;
  logic [CW-1:0]      count;
  logic [15:0]        overflow_cnt;
  logic               frozen;

  riscv_trace_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .STAMP_W(STAMP_W), .TRIG_MODE(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .trig_en(trig_en),
    .trig_addr(trig_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_kind(out_kind), .out_tag(out_tag),
    .out_data(out_data), .out_stamp(out_stamp), .count(count),
    .overflow_cnt(overflow_cnt), .frozen(frozen)
  );

  typedef struct packed {
    logic [1:0]         k;
    logic [ADDR_W-1:0]  t;
    logic [DATA_W-1:0]  d;
    logic [STAMP_W-1:0] s;
  } ent_t;

  ent_t mq[$];
  int   movf;
  bit   mfrz;
  int   mstamp;
  int   nvec;
  int   nerr;

  wire [BW-1:0] dut_b = {out_valid, out_kind, out_tag, out_data,
                         out_stamp, count, overflow_cnt, frozen};

  function automatic logic [BW-1:0] exp_b();
    ent_t h = '0;
    if (mq.size() != 0) h = mq[0];
    return {mq.size() != 0, h.k, h.t, h.d, h.s,
            CW'(mq.size()), 16'(movf), mfrz};
  endfunction

  function automatic void model_reset();
    mq.delete();
    movf   = 0;
    mfrz   = 1'b0;
    mstamp = 0;
  endfunction

  function automatic void add_drop();
    if (movf < 65535) movf++;
  endfunction

  task automatic idle();
    enable = 1'b1; clear = 1'b0;
    reg_write_sig = 1'b0; wr = 1'b0; rd = 1'b0;
    out_ready = 1'b0;
  endtask

  // One clock edge; the model consumes the inputs held across the edge
  task automatic step();
    int free;
    bit popd;
    @(posedge clk);
    free = DEPTH - mq.size();
    popd = (mq.size() != 0) && out_ready;
    if (clear) begin
      mq.delete();
      movf = 0;
      mfrz = 1'b0;
    end else begin
      if (popd) void'(mq.pop_front());
      if (enable && !mfrz) begin
        if (wr || rd) begin
          if (free > 0) begin
            mq.push_back({wr ? 2'b11 : 2'b10, addr,
                          wr ? wr_data : rd_data, STAMP_W'(mstamp)});
            free--;
          end else add_drop();
        end
        if (reg_write_sig) begin
          if (free > 0) begin
            mq.push_back({2'b01, ADDR_W'(reg_num), reg_data,
                          STAMP_W'(mstamp)});
            free--;
          end else add_drop();
        end
        if (trig_en && (wr || rd) && addr == trig_addr) mfrz = 1'b1;
      end
    end
    mstamp++;
    #1;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    nvec++;
    if (dut_b !== exp_b()) begin
      $display("FAIL reset_bundle got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
    nvec++;
    if ({out_valid, count, overflow_cnt, frozen} !== '0) begin
      $display("FAIL reset_zero got=%b/%0d/%0d/%b exp=0",
               out_valid, count, overflow_cnt, frozen);
      nerr++;
    end
  endtask

  task automatic test_store();
    logic [STAMP_W-1:0] cap_st;
    idle();
    wr = 1'b1; addr = 9'h04; wr_data = 32'hDEAD_BEEF;
    cap_st = STAMP_W'(mstamp);
    step();
    idle();
    nvec++;
    if ({out_valid, out_kind, out_tag, out_data, out_stamp} !==
        {1'b1, 2'b11, 9'h004, 32'hDEAD_BEEF, cap_st}) begin
      $display("FAIL store_head got=%b %b %h %h %0d exp=1 11 004 deadbeef %0d",
               out_valid, out_kind, out_tag, out_data, out_stamp, cap_st);
      nerr++;
    end
    out_ready = 1'b1;
    step();
    idle();
    nvec++;
    if (count !== CW'(0) || dut_b !== exp_b()) begin
      $display("FAIL store_pop got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
  endtask

  task automatic test_load_reg();
    idle();
    rd = 1'b1; addr = 9'h008; rd_data = 32'd5;
    reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'd5;
    step();
    idle();
    nvec++;
    if (count !== CW'(2) || out_kind !== 2'b10 || out_tag !== 9'h008) begin
      $display("FAIL load_first got=%0d %b %h exp=2 10 008",
               count, out_kind, out_tag);
      nerr++;
    end
    out_ready = 1'b1;
    step();
    nvec++;
    if (out_kind !== 2'b01 || out_tag !== 9'h003 || dut_b !== exp_b()) begin
      $display("FAIL load_second got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
    step();
    idle();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 17; i++) begin
      reg_write_sig = 1'b1;
      reg_num  = 5'($urandom_range(0, 31));
      reg_data = $urandom;
      step();
    end
    idle();
    nvec++;
    if (count !== CW'(16) || overflow_cnt !== 16'd1) begin
      $display("FAIL ovf_fill got=%0d/%0d exp=16/1", count, overflow_cnt);
      nerr++;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nvec++;
      if (dut_b !== exp_b()) begin
        $display("FAIL ovf_drain%0d got=%h exp=%h", i, dut_b, exp_b());
        nerr++;
      end
      step();
    end
    idle();
  endtask

  task automatic test_full_pop();
    do_clear();
    for (int i = 0; i < 15; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = $urandom;
      step();
    end
    wr = 1'b1; addr = 9'h1A; wr_data = $urandom;
    reg_num = 5'd7;
    step();
    idle();
    nvec++;
    if (count !== CW'(16) || overflow_cnt !== 16'd1 ||
        dut_b !== exp_b()) begin
      $display("FAIL full_mem_reg got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
    out_ready = 1'b1;
    step();
    rd = 1'b1; addr = 9'h0C; rd_data = $urandom;
    reg_write_sig = 1'b1; reg_num = 5'd9;
    step();
    idle();
    nvec++;
    if (count !== CW'(15) || overflow_cnt !== 16'd2 ||
        dut_b !== exp_b()) begin
      $display("FAIL full_pop got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
  endtask

  task automatic test_trigger();
    do_clear();
    trig_en = 1'b1; trig_addr = 9'h010;
    wr = 1'b1; addr = 9'h010; wr_data = $urandom;
    step();
    nvec++;
    if (frozen !== 1'b1 || count !== CW'(1)) begin
      $display("FAIL trig_hit got=%b/%0d exp=1/1", frozen, count);
      nerr++;
    end
    for (int i = 0; i < 3; i++) begin
      addr = 9'(i + 1); wr_data = $urandom;
      step();
    end
    idle();
    nvec++;
    if (count !== CW'(1) || overflow_cnt !== 16'd0 ||
        dut_b !== exp_b()) begin
      $display("FAIL trig_frozen got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
    do_clear();
    trig_en = 1'b0;
    nvec++;
    if (frozen !== 1'b0 || count !== CW'(0)) begin
      $display("FAIL trig_clear got=%b/%0d exp=0/0", frozen, count);
      nerr++;
    end
  endtask

  task automatic test_random();
    trig_addr = 9'h005;
    for (int i = 0; i < 400; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 49) == 0);
      wr            = 1'($urandom);
      rd            = 1'($urandom);
      reg_write_sig = 1'($urandom);
      reg_num       = 5'($urandom);
      reg_data      = $urandom;
      addr          = 9'($urandom_range(0, 31));
      wr_data       = $urandom;
      rd_data       = $urandom;
      trig_en       = ($urandom_range(0, 3) == 0);
      out_ready     = ($urandom_range(0, 2) == 0);
      step();
      nvec++;
      if (dut_b !== exp_b()) begin
        $display("FAIL rand%0d got=%h exp=%h", i, dut_b, exp_b());
        nerr++;
      end
    end
    trig_en = 1'b0;
    do_clear();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = $urandom;
      step();
    end
    idle();
    out_ready = 1'b1;
    step();
    step();
    #2 reset = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (dut_b !== '0) begin
      $display("FAIL reset_mid got=%h exp=0", dut_b);
      nerr++;
    end
    @(negedge clk);
    reset = 1'b1;
    idle();
    wr = 1'b1; addr = 9'h0AB; wr_data = $urandom;
    step();
    idle();
    nvec++;
    if (out_stamp !== STAMP_W'(0) || dut_b !== exp_b()) begin
      $display("FAIL reset_stamp got=%h exp=%h", dut_b, exp_b());
      nerr++;
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset = 1'b0;
    idle();
    reg_num = '0; reg_data = '0; addr = '0;
    wr_data = '0; rd_data = '0;
    trig_en = 1'b0; trig_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_store();
    test_load_reg();
    test_overflow();
    test_full_pop();
    test_trigger();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
